// File: rtl/pf_pkg.sv
// Shared playfield constants: RAM geometry and the fetch FSM state encoding.
// The RAM and the tile renderer use the same address constants.
package pf_pkg;
    localparam int PF_ADDR_W     = 8;
    localparam int PF_COL_W      = 4;
    localparam int PF_ROW_W      = 4;
    localparam int PF_TILE_SHIFT = 4;
    localparam int PF_IDX_W      = 5;
    localparam int PF_WORD_W     = 32;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ADDR = 2'd1;
    localparam logic [1:0] DATA = 2'd2;
    localparam logic [1:0] OUT  = 2'd3;
endpackage

// File: rtl/pf_fetch_if.sv
// Playfield fetch bus: RAM port b read side plus the tile-word handshake to the renderer.
// master = fetch engine, slave = RAM/renderer side.
interface pf_fetch_if;
    logic [pf_pkg::PF_ADDR_W-1:0]     addr_b;
    logic [3:0]                       ce_b;
    logic [pf_pkg::PF_WORD_W-1:0]     dout_b;
    logic                             out_valid;
    logic                             out_ready;
    logic [pf_pkg::PF_WORD_W-1:0]     out_word;
    logic [pf_pkg::PF_IDX_W-1:0]      out_idx;
    logic [pf_pkg::PF_TILE_SHIFT-1:0] out_fine_x;
    logic [pf_pkg::PF_TILE_SHIFT-1:0] out_fine_y;

    modport master (
        output addr_b, ce_b, out_valid, out_word, out_idx, out_fine_x, out_fine_y,
        input  dout_b, out_ready
    );

    modport slave (
        input  addr_b, ce_b, out_valid, out_word, out_idx, out_fine_x, out_fine_y,
        output dout_b, out_ready
    );
endinterface

// File: rtl/pf_fetch.sv
// Playfield line fetcher: on line_start reads NTILES consecutive tile words of one map row
// from RAM port b (column wraps within the row) and hands them to the renderer one at a time.
module pf_fetch
    import pf_pkg::*;
#(
    parameter int NTILES     = 17,
    parameter int COL_BITS   = PF_COL_W,
    parameter int ROW_BITS   = PF_ROW_W,
    parameter int TILE_SHIFT = PF_TILE_SHIFT
) (
    input  logic        clk_b,
    input  logic        reset,
    input  logic        line_start,
    input  logic [7:0]  line_v,
    input  logic [7:0]  scroll_x,
    input  logic [7:0]  scroll_y,
    output logic        busy,
    output logic        overrun,
    pf_fetch_if.master  pf
);

    logic [1:0]                      r_state;
    logic [ROW_BITS-1:0]             r_row;
    logic [COL_BITS-1:0]             r_col0;
    logic [PF_IDX_W-1:0]             r_n;
    logic [PF_ADDR_W-1:0]            r_addr;
    logic [3:0]                      r_ce;
    logic                            r_valid;
    logic [PF_WORD_W-1:0]            r_word;
    logic [PF_IDX_W-1:0]             r_idx;
    logic [TILE_SHIFT-1:0]           r_fine_x;
    logic [TILE_SHIFT-1:0]           r_fine_y;
    logic                            r_overrun;

    logic [7:0]                      w_vy;
    logic [PF_IDX_W-1:0]             w_n_nxt;
    logic [COL_BITS-1:0]             w_col_nxt;
    logic                            w_last;
    logic                            w_final_hs;
    logic                            w_ovr;

    assign w_vy       = line_v + scroll_y;
    assign w_n_nxt    = r_n + 5'd1;
    assign w_col_nxt  = r_col0 + COL_BITS'(w_n_nxt);
    assign w_last     = (r_n == PF_IDX_W'(NTILES - 1));
    assign w_final_hs = (r_state == OUT) && pf.out_ready && w_last;
    // A line_start landing on the last handshake is a clean back-to-back line, not an overrun.
    assign w_ovr      = line_start && (r_state != IDLE) && !w_final_hs;

    always_ff @(posedge clk_b) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_row     <= '0;
            r_col0    <= '0;
            r_n       <= '0;
            r_addr    <= '0;
            r_ce      <= 4'b1111;
            r_valid   <= 1'b0;
            r_word    <= '0;
            r_idx     <= '0;
            r_fine_x  <= '0;
            r_fine_y  <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= w_ovr;
            if (line_start) begin
                r_row    <= w_vy[7 -: ROW_BITS];
                r_col0   <= scroll_x[7 -: COL_BITS];
                r_fine_x <= scroll_x[TILE_SHIFT-1:0];
                r_fine_y <= w_vy[TILE_SHIFT-1:0];
                r_n      <= '0;
                r_addr   <= {w_vy[7 -: ROW_BITS], scroll_x[7 -: COL_BITS]};
                r_ce     <= 4'b0000;
                r_valid  <= 1'b0;
                r_state  <= ADDR;
            end else begin
                case (r_state)
                    IDLE: r_state <= IDLE;
                    ADDR: r_state <= DATA;
                    DATA: begin
                        // Only point where RAM data is sampled; later port-a writes cannot leak in.
                        r_word  <= pf.dout_b;
                        r_idx   <= r_n;
                        r_valid <= 1'b1;
                        r_ce    <= 4'b1111;
                        r_state <= OUT;
                    end
                    OUT: begin
                        if (pf.out_ready) begin
                            r_valid <= 1'b0;
                            if (w_last) begin
                                r_state <= IDLE;
                            end else begin
                                r_n     <= w_n_nxt;
                                r_addr  <= {r_row, w_col_nxt};
                                r_ce    <= 4'b0000;
                                r_state <= ADDR;
                            end
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign busy          = (r_state != IDLE);
    assign overrun       = r_overrun;
    assign pf.addr_b     = r_addr;
    assign pf.ce_b       = r_ce;
    assign pf.out_valid  = r_valid;
    assign pf.out_word   = r_word;
    assign pf.out_idx    = r_idx;
    assign pf.out_fine_x = r_fine_x;
    assign pf.out_fine_y = r_fine_y;

endmodule
